uart_duplex: RTL and testbench

- Full-duplex UART with independent transmitter and receiver, one start bit, 8 data bits (LSB first), optional parity bit, one stop bit.
- Runtime-selectable baud rate and parity.
- Sits between byte-level protocol logic (sensor report sender, LED command parser) and the board serial pins.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_duplex.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_duplex.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings, FSM state types and timing/parity helpers for the
// full-duplex UART.
package uart_pkg;

    localparam int PERIOD_W = 20;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam int BAUD_VAL_2400  = 2400;
    localparam int BAUD_VAL_4800  = 4800;
    localparam int BAUD_VAL_9600  = 9600;
    localparam int BAUD_VAL_19200 = 19200;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    function automatic logic [PERIOD_W-1:0] bit_period(input logic [1:0] baud_rate,
                                                       input int clk_freq);
        int baud;
        baud = BAUD_VAL_9600;
        unique case (baud_rate)
            BAUD_2400:  baud = BAUD_VAL_2400;
            BAUD_4800:  baud = BAUD_VAL_4800;
            BAUD_9600:  baud = BAUD_VAL_9600;
            BAUD_19200: baud = BAUD_VAL_19200;
            default:    baud = BAUD_VAL_9600;
        endcase
        return PERIOD_W'(clk_freq / baud);
    endfunction

    // Encoding 2'b11 is a second spelling of "no parity".
    function automatic logic parity_enabled(input logic [1:0] parity_type);
        return (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] parity_type);
        return (parity_type == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable down-counter: load latches a period, tick pulses for one clock
// each time that period elapses, and the count reloads automatically.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count;
    logic                running;

    assign tick = running && (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            count    <= '0;
            running  <= 1'b0;
        end else if (load) begin
            period_q <= period;
            count    <= period - 1'b1;
            running  <= 1'b1;
        end else if (tick) begin
            count <= period_q - 1'b1;
        end else if (running) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_duplex.sv
// Full-duplex UART: 8 data bits LSB first, optional odd/even parity, one stop
// bit; baud and parity are captured per frame, independently for TX and RX.
module uart_duplex
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic [7:0] data_transmit,
    input  logic       rx,
    output logic       tx,
    output logic       tx_active_flag,
    output logic       tx_done_flag,
    output logic       rx_active_flag,
    output logic       rx_done_flag,
    output logic [7:0] data_received,
    output logic [2:0] error_flag
);

    logic [PERIOD_W-1:0] live_period;
    logic [PERIOD_W-1:0] live_half;

    assign live_period = bit_period(baud_rate, CLK_FREQ);
    assign live_half   = (live_period > PERIOD_W'(1)) ? (live_period >> 1) : PERIOD_W'(1);

    // ---------------------------------------------------------------- TX
    tx_state_t  tx_state, tx_state_next;
    logic [7:0] tx_data, tx_data_next;
    logic [2:0] tx_idx, tx_idx_next;
    logic [1:0] tx_par, tx_par_next;
    logic       tx_next, tx_active_next, tx_done_next;
    logic       tx_load, tx_tick;

    uart_bit_timer u_tx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tx_load),
        .period (live_period),
        .tick   (tx_tick)
    );

    // The line value is registered alongside the state so tx never glitches.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tx_state_next  = tx_state;
        tx_data_next   = tx_data;
        tx_idx_next    = tx_idx;
        tx_par_next    = tx_par;
        tx_next        = tx;
        tx_active_next = tx_active_flag;
        tx_done_next   = tx_done_flag;
        tx_load        = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_next = 1'b1;
                if (send) begin
                    tx_state_next  = TX_START;
                    tx_data_next   = data_transmit;
                    tx_par_next    = parity_type;
                    tx_idx_next    = '0;
                    tx_next        = 1'b0;
                    tx_active_next = 1'b1;
                    tx_done_next   = 1'b0;
                    tx_load        = 1'b1;
                end
            end
            TX_START: if (tx_tick) begin
                tx_state_next = TX_DATA;
                tx_next       = tx_data[0];
            end
            TX_DATA: if (tx_tick) begin
                if (tx_idx == 3'd7) begin
                    if (parity_enabled(tx_par)) begin
                        tx_state_next = TX_PARITY;
                        tx_next       = parity_bit(tx_data, tx_par);
                    end else begin
                        tx_state_next = TX_STOP;
                        tx_next       = 1'b1;
                    end
                end else begin
                    tx_idx_next = tx_idx + 3'd1;
                    tx_next     = tx_data[tx_idx + 3'd1];
                end
            end
            TX_PARITY: if (tx_tick) begin
                tx_state_next = TX_STOP;
                tx_next       = 1'b1;
            end
            TX_STOP: if (tx_tick) begin
                tx_state_next  = TX_IDLE;
                tx_active_next = 1'b0;
                tx_done_next   = 1'b1;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state       <= TX_IDLE;
            tx_data        <= '0;
            tx_idx         <= '0;
            tx_par         <= PAR_NONE;
            tx             <= 1'b1;
            tx_active_flag <= 1'b0;
            tx_done_flag   <= 1'b0;
        end else begin
            tx_state       <= tx_state_next;
            tx_data        <= tx_data_next;
            tx_idx         <= tx_idx_next;
            tx_par         <= tx_par_next;
            tx             <= tx_next;
            tx_active_flag <= tx_active_next;
            tx_done_flag   <= tx_done_next;
        end
    end

    // ---------------------------------------------------------------- RX
    logic rx_meta, rx_sync, rx_prev, rx_fall;

    // Synchronizer resets to the idle level so reset release cannot look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    rx_state_t           rx_state, rx_state_next;
    logic [7:0]          rx_shift, rx_shift_next;
    logic [2:0]          rx_idx, rx_idx_next;
    logic [1:0]          rx_par, rx_par_next;
    logic                rx_par_err, rx_par_err_next;
    logic [PERIOD_W-1:0] rx_len, rx_len_next, rx_load_val;
    logic                rx_load, rx_tick;
    logic                rx_active_next, rx_done_next;
    logic [7:0]          data_received_next;
    logic [2:0]          error_flag_next;

    uart_bit_timer u_rx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (rx_load),
        .period (rx_load_val),
        .tick   (rx_tick)
    );

    // First timeout is half a bit to land on the start-bit centre; full bits follow.
    always_comb begin
        rx_state_next      = rx_state;
        rx_shift_next      = rx_shift;
        rx_idx_next        = rx_idx;
        rx_par_next        = rx_par;
        rx_par_err_next    = rx_par_err;
        rx_len_next        = rx_len;
        rx_load            = 1'b0;
        rx_load_val        = rx_len;
        rx_active_next     = rx_active_flag;
        rx_done_next       = 1'b0;
        data_received_next = data_received;
        error_flag_next    = error_flag;
        unique case (rx_state)
            RX_IDLE: if (rx_fall) begin
                rx_state_next   = RX_START;
                rx_active_next  = 1'b1;
                rx_len_next     = live_period;
                rx_par_next     = parity_type;
                rx_par_err_next = 1'b0;
                rx_load         = 1'b1;
                rx_load_val     = live_half;
            end
            RX_START: if (rx_tick) begin
                if (!rx_sync) begin
                    rx_state_next = RX_DATA;
                    rx_idx_next   = '0;
                    rx_load       = 1'b1;
                end else begin
                    rx_state_next  = RX_IDLE;
                    rx_active_next = 1'b0;
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_next = {rx_sync, rx_shift[7:1]};
                if (rx_idx == 3'd7) begin
                    rx_state_next = parity_enabled(rx_par) ? RX_PARITY : RX_STOP;
                end else begin
                    rx_idx_next = rx_idx + 3'd1;
                end
            end
            RX_PARITY: if (rx_tick) begin
                rx_par_err_next = (rx_sync != parity_bit(rx_shift, rx_par));
                rx_state_next   = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_next      = RX_IDLE;
                rx_active_next     = 1'b0;
                rx_done_next       = 1'b1;
                data_received_next = rx_shift;
                error_flag_next    = {!rx_sync, 1'b0, rx_par_err};
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state       <= RX_IDLE;
            rx_shift       <= '0;
            rx_idx         <= '0;
            rx_par         <= PAR_NONE;
            rx_par_err     <= 1'b0;
            rx_len         <= '0;
            rx_active_flag <= 1'b0;
            rx_done_flag   <= 1'b0;
            data_received  <= '0;
            error_flag     <= '0;
        end else begin
            rx_state       <= rx_state_next;
            rx_shift       <= rx_shift_next;
            rx_idx         <= rx_idx_next;
            rx_par         <= rx_par_next;
            rx_par_err     <= rx_par_err_next;
            rx_len         <= rx_len_next;
            rx_active_flag <= rx_active_next;
            rx_done_flag   <= rx_done_next;
            data_received  <= data_received_next;
            error_flag     <= error_flag_next;
        end
    end

endmodule

// File: tb/tb_uart_duplex.sv
// Randomized scoreboard bench for uart_duplex: stimulus queues expected frames,
// independent monitors decode tx and rx_done and compare against them.
module tb_uart_duplex;

    localparam int TB_CLK = 96000;

    logic       clk, rst_n, send, rx;
    logic [1:0] parity_type, baud_rate;
    logic [7:0] data_transmit;
    logic       tx, tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag;
    logic [7:0] data_received;
    logic [2:0] error_flag;

    uart_duplex #(.CLK_FREQ(TB_CLK)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .send           (send),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .data_transmit  (data_transmit),
        .rx             (rx),
        .tx             (tx),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag),
        .data_received  (data_received),
        .error_flag     (error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] pt;
        logic [1:0] br;
        bit         b2b;
    } tx_item_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] err;
    } rx_item_t;

    tx_item_t tx_exp_q[$];
    rx_item_t rx_exp_q[$];
    int       total = 0;
    int       bad   = 0;
    bit       tx_mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: frame layout and timing from first principles.
    function automatic int bit_clks(input logic [1:0] br);
        return TB_CLK / (2400 << br);
    endfunction

    function automatic bit par_on(input logic [1:0] pt);
        return (pt == 2'b01) || (pt == 2'b10);
    endfunction

    // Odd: data+parity holds an odd number of ones; even: an even number.
    function automatic bit exp_par(input logic [7:0] d, input logic [1:0] pt);
        int ones;
        ones = $countones(d);
        return (pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tx_active_flag;
            1:       return tx_done_flag;
            default: return rx_active_flag;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (sig(sel) === val) seen = 1'b1;
        end
        check(name, 32'(seen), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx"},            32'(tx), 1);
        check({tag, "_tx_active"},     32'(tx_active_flag), 0);
        check({tag, "_tx_done"},       32'(tx_done_flag), 0);
        check({tag, "_rx_active"},     32'(rx_active_flag), 0);
        check({tag, "_rx_done"},       32'(rx_done_flag), 0);
        check({tag, "_data_received"}, 32'(data_received), 0);
        check({tag, "_error_flag"},    32'(error_flag), 0);
    endtask

    // ---------------------------------------------------------- TX monitor
    initial begin : tx_monitor
        tx_item_t it;
        int       bt;
        int       idle_cnt;
        bit       exp_bits[$];
        logic     got;
        idle_cnt = 1000;
        forever begin
            @(negedge clk);
            if (!tx_mon_en) begin
                idle_cnt = 1000;
            end else if (tx === 1'b1) begin
                idle_cnt++;
            end else if (tx_exp_q.size() == 0) begin
                check("tx_unexpected_frame", 1, 0);
                for (int k = 0; k < 1000 && tx_done_flag !== 1'b1; k++) @(negedge clk);
                idle_cnt = 0;
            end else begin
                it = tx_exp_q.pop_front();
                bt = bit_clks(it.br);
                exp_bits = {};
                exp_bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) exp_bits.push_back(it.d[i]);
                if (par_on(it.pt)) exp_bits.push_back(exp_par(it.d, it.pt));
                exp_bits.push_back(1'b1);
                if (it.b2b) check("tx_idle_gap", 32'(idle_cnt), 1);
                check("tx_active_start", 32'(tx_active_flag), 1);
                check("tx_done_start", 32'(tx_done_flag), 0);
                for (int b = 0; b < exp_bits.size(); b++) begin
                    got = exp_bits[b];
                    for (int k = 0; k < bt; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (tx !== exp_bits[b]) got = tx;
                    end
                    check($sformatf("tx_bit%0d_of_%02h", b, it.d), 32'(got), 32'(exp_bits[b]));
                end
                @(negedge clk);
                check("tx_done_end", 32'(tx_done_flag), 1);
                check("tx_active_end", 32'(tx_active_flag), 0);
                check("tx_idle_line", 32'(tx), 1);
                idle_cnt = 1;
            end
        end
    end

    // ---------------------------------------------------------- RX monitor
    initial begin : rx_monitor
        rx_item_t it;
        logic     prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done_flag === 1'b1) begin
                check("rx_done_width", 32'(prev), 0);
                if (rx_exp_q.size() == 0) begin
                    check("rx_unexpected_done", 1, 0);
                end else begin
                    it = rx_exp_q.pop_front();
                    check("rx_data", 32'(data_received), 32'(it.d));
                    check("rx_error_flag", 32'(error_flag), 32'(it.err));
                    check("rx_active_end", 32'(rx_active_flag), 0);
                end
            end
            prev = rx_done_flag;
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic tx_seq(input int n, input logic [1:0] pt, input logic [1:0] br,
                          input logic [7:0] first, input bit scramble);
        tx_item_t   it;
        logic [7:0] d;
        int         bt;
        bt = bit_clks(br);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? first : 8'($urandom);
            parity_type   = pt;
            baud_rate     = br;
            data_transmit = d;
            send          = 1'b1;
            it.d = d; it.pt = pt; it.br = br; it.b2b = (i > 0);
            tx_exp_q.push_back(it);
            if (i == 0) begin
                wait_for(0, 1'b1, 5, "tx_frame_start");
            end else begin
                wait_for(1, 1'b1, 12 * bt + 20, "tx_b2b_prev_end");
                wait_for(0, 1'b1, 3, "tx_b2b_start");
            end
            if (scramble) begin
                data_transmit = 8'($urandom);
                parity_type   = 2'($urandom);
                baud_rate     = 2'($urandom);
            end
        end
        send = 1'b0;
        wait_for(1, 1'b1, 12 * bt + 20, "tx_frame_end");
        repeat (2) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br,
                            input bit bad_par, input bit bad_stop);
        rx_item_t it;
        int       bt;
        bt = bit_clks(br);
        parity_type = pt;
        baud_rate   = br;
        it.d   = d;
        it.err = {bad_stop, 1'b0, bad_par & par_on(pt)};
        rx_exp_q.push_back(it);
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bt) @(negedge clk);
        end
        if (par_on(pt)) begin
            rx = exp_par(d, pt) ^ bad_par;
            repeat (bt) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (bt) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bt) @(negedge clk);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit         seen;
        logic [1:0] pt, br;
        rst_n = 1'b0; send = 1'b0; rx = 1'b1;
        parity_type = 2'b01; baud_rate = 2'b10; data_transmit = '0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed RX at BIT=10, odd parity.
        rx_frame(8'h4C, 2'b01, 2'b10, 1'b0, 1'b0);
        rx_frame(8'h31, 2'b01, 2'b10, 1'b1, 1'b0);
        rx_frame(8'hC3, 2'b01, 2'b10, 1'b0, 1'b1);

        // Start-bit glitch shorter than half a bit.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rx_active_flag === 1'b1) seen = 1'b1;
        end
        check("glitch_rx_active_seen", 32'(seen), 1);
        check("glitch_rx_active_clear", 32'(rx_active_flag), 0);

        // Asynchronous reset in the middle of both a TX and an RX frame.
        parity_type = 2'b01; baud_rate = 2'b10; data_transmit = 8'hA5; send = 1'b1; rx = 1'b0;
        repeat (25) @(negedge clk);
        check("pre_reset_tx_active", 32'(tx_active_flag), 1);
        check("pre_reset_rx_active", 32'(rx_active_flag), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_reset");
        send = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("post_reset_tx", 32'(tx), 1);
        check("post_reset_tx_active", 32'(tx_active_flag), 0);
        check("post_reset_tx_done", 32'(tx_done_flag), 0);
        check("post_reset_rx_active", 32'(rx_active_flag), 0);

        // Directed TX: odd parity back-to-back, then none/even at BIT=5.
        tx_mon_en = 1'b1;
        tx_seq(2, 2'b01, 2'b10, 8'h53, 1'b1);
        tx_seq(1, 2'b00, 2'b11, 8'h0A, 1'b1);
        tx_seq(1, 2'b10, 2'b11, 8'h0A, 1'b1);
        tx_seq(1, 2'b11, 2'b11, 8'h0A, 1'b1);

        // Randomized TX and RX.
        for (int k = 0; k < 4; k++)
            tx_seq(1 + $urandom_range(0, 1), 2'($urandom), 2'($urandom), 8'($urandom), 1'b1);
        for (int k = 0; k < 6; k++)
            rx_frame(8'($urandom), 2'($urandom), 2'($urandom),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        // Simultaneous TX and RX with shared settings.
        pt = 2'($urandom);
        br = 2'($urandom_range(2, 3));
        fork
            tx_seq(2, pt, br, 8'($urandom), 1'b0);
            for (int k = 0; k < 3; k++) rx_frame(8'($urandom), pt, br, 1'b0, 1'b0);
        join

        repeat (20) @(negedge clk);
        check("tx_queue_drained", 32'(tx_exp_q.size()), 0);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
